syn_acache_pcm_fetch_ctrl: RTL
==============================

// Module: syn_acache_pcm_fetch_ctrl
// PURPOSE
//  Sequences FGYRUS-side (port B) reads of the audio cache ping-pong PCM buffers.
//  On each buffer-swap pulse it reads all 2^P_PCM_RAM_ADDR_W L/R sample pairs in order.
//  It streams them to the FFT loader over a valid/ready handshake, using a credit-limited skid FIFO.
//  It shares the same read port with a local-bus debug reader under a bounded-wait arbiter.
// PARAMETERS
//  P_PCM_RAM_DATA_W  32  sample width per channel
//  P_PCM_RAM_ADDR_W  7   buffer address width (frame = 128 pairs)
//  P_RAM_RD_DELAY    2   rden -> rdata latency of cache port B, cycles (>=1)
//  P_SKID_DEPTH      4   sample FIFO depth (power of 2, >= P_RAM_RD_DELAY+1)
//  P_LB_MAX_WAIT     8   max cycles an LB read waits before it takes the next port slot
// PORTS
//  clk_ir        in   1    clock (FGYRUS domain)
//  rst_ir        in   1    asynchronous reset, active-high
//  fetch_en      in   1    enables frame fetches
//  pcm_rdy_oh    in   1    1-cycle pulse: new frame ready (swap), already in clk_ir domain
//  mem_addr      out  7    port B address (to L and R buffers)
//  mem_rden      out  1    port B read strobe
//  mem_lrdata    in   32   L-channel read data
//  mem_rrdata    in   32   R-channel read data
//  mem_rd_valid  in   1    read data valid, P_RAM_RD_DELAY after mem_rden
//  smpl_valid    out  1    sample pair valid
//  smpl_ready    in   1    sink accepts when valid&ready
//  smpl_lchnnl   out  32   L sample
//  smpl_rchnnl   out  32   R sample
//  smpl_idx      out  7    sample index within frame
//  smpl_last     out  1    marks idx==127
//  lb_rd_en      in   1    debug read request pulse
//  lb_rd_addr    in   8    [7]=0 L / 1 R, [6:0] buffer address
//  lb_rd_valid   out  1    1-cycle pulse with lb_rd_data
//  lb_rd_data    out  32   debug read data
//  busy          out  1    FSM not IDLE
//  frame_done_oh out  1    1-cycle pulse: last sample accepted by sink
//  ovrn_cnt      out  8    saturating count of pcm_rdy_oh while busy
//  ovrn_clr      in   1    clears ovrn_cnt (wins over a same-cycle increment)
//  tag_err       out  1    sticky: mem_rd_valid with no tag outstanding, or tag without valid
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, fetch addr 0, no LB read pending.
//  FSM IDLE: on pcm_rdy_oh & fetch_en -> FETCH, addr=0. A pulse with fetch_en=0 is ignored and not counted.
//  FSM FETCH: issues one fetch read per granted cycle, addr increments.
//    After the read of addr 127 is issued -> DRAIN.
//  FSM DRAIN: -> IDLE when outstanding==0 & FIFO empty. frame_done_oh fires on acceptance of smpl_last.
//  fetch_en deassert mid-frame: the current frame completes; only new frames are blocked.
//  pcm_rdy_oh while busy: ovrn_cnt +1, saturating at 255. The frame is not restarted and the pulse is not queued.
//  Credit: a fetch read is issued only if fifo_count + fetch_outstanding < P_SKID_DEPTH.
//    This guarantees the FIFO never overflows.
//  Tag pipe: P_RAM_RD_DELAY-stage shift of {vld, src(FETCH/LB)} loaded with each rden.
//    On mem_rd_valid, data routes by head tag src.
//    A valid/tag mismatch sets tag_err and drops the data.
//  Arbiter, one rden per cycle:
//    - The LB read wins if pending and (no fetch read eligible this cycle, or LB wait count >= P_LB_MAX_WAIT).
//    - Otherwise the fetch read wins.
//  LB: one request held pending. lb_rd_en while pending or outstanding is ignored.
//    On return, lb_rd_data = addr[7] ? rrdata : ldata, lb_rd_valid pulses 1 cycle.
//    LB wait counter resets on grant.
//  FIFO: registered, smpl_* = head. smpl_valid = !empty. Simultaneous push and pop keeps the count.
//  Latency: with pcm_rdy_oh in cycle N, smpl_ready=1 and no LB traffic:
//    - mem_rden fires in N+1..N+128 back-to-back;
//    - the first smpl_valid appears in cycle N+2+P_RAM_RD_DELAY;
//    - samples then follow 1 per cycle.
//  smpl_idx wraps 127->0 per frame. It is taken from an accepted-sample counter, not the read address.
//  Async reset mid-frame: all state cleared immediately, in-flight returns discarded.
//    A post-reset mem_rd_valid from a pre-reset read sets tag_err.
// TESTING
//  1. Stall-free frame: fetch_en=1, pcm_rdy_oh at cycle 10, ready=1.
//     -> rden cycles 11..138; valid cycles 14..141; idx 0..127; last at 127; frame_done_oh cycle 141.
//  2. Backpressure: ready toggles 1,0,0,1 repeatedly.
//     -> never >4 in flight+queued; all 128 pairs in order, none lost or duplicated.
//  3. Overrun: pcm_rdy_oh at cycles 10 and 60.
//     -> ovrn_cnt=1, single frame; 300 pulses while busy -> ovrn_cnt=255; ovrn_clr -> 0.
//  4. LB arbitration: lb_rd_en addr 0x85 during frame with ready=1.
//     -> granted within 8 cycles; lb_rd_valid with R[5]; frame data intact.
//  5. Idle LB read: lb_rd_en addr 0x03 in IDLE.
//     -> rden next cycle, lb_rd_valid 1+P_RAM_RD_DELAY cycles later; 2nd lb_rd_en while pending ignored.
//  6. Reset at cycle 50 of a frame -> all outputs 0 instantly; next pcm_rdy_oh fetches from addr 0.

Source files
------------

// File: rtl/syn_acache_pcm_fetch_ctrl.sv
`timescale 1ns / 1ps
// syn_acache_pcm_fetch_ctrl
//   Reads the audio cache ping-pong PCM buffers through port B on behalf of
//   the FGYRUS FFT loader. Each buffer-swap pulse starts a fetch of a whole
//   frame of L/R sample pairs. The pairs are streamed out over valid/ready
//   through a small credit-limited skid FIFO. The same port B is shared with
//   a local-bus debug reader under a bounded-wait arbiter.
//
// Ports
//   clk_ir, rst_ir          clock, asynchronous active-high reset
//   fetch_en                allows new frame fetches to start
//   pcm_rdy_oh              one-cycle swap pulse: a new frame is ready
//   mem_addr/mem_rden       port B address and read strobe
//   mem_lrdata/mem_rrdata   L/R read data, qualified by mem_rd_valid
//   smpl_valid/smpl_ready   sample stream handshake
//   smpl_lchnnl/rchnnl      sample pair at the FIFO head
//   smpl_idx/smpl_last      index of the pair within the frame, last marker
//   lb_rd_en/lb_rd_addr     debug read request ([7] selects R, [6:0] address)
//   lb_rd_valid/lb_rd_data  debug read return pulse and data
//   busy                    a frame is being fetched or drained
//   frame_done_oh           pulse when the last pair of a frame is accepted
//   ovrn_cnt/ovrn_clr       saturating count of swap pulses seen while busy
//   tag_err                 sticky: read data and issued reads went out of step
module syn_acache_pcm_fetch_ctrl #(
  parameter int P_PCM_RAM_DATA_W = 32,
  parameter int P_PCM_RAM_ADDR_W = 7,
  parameter int P_RAM_RD_DELAY   = 2,
  parameter int P_SKID_DEPTH     = 4,
  parameter int P_LB_MAX_WAIT    = 8
) (
  input  logic                        clk_ir,
  input  logic                        rst_ir,
  input  logic                        fetch_en,
  input  logic                        pcm_rdy_oh,
  output logic [P_PCM_RAM_ADDR_W-1:0] mem_addr,
  output logic                        mem_rden,
  input  logic [P_PCM_RAM_DATA_W-1:0] mem_lrdata,
  input  logic [P_PCM_RAM_DATA_W-1:0] mem_rrdata,
  input  logic                        mem_rd_valid,
  output logic                        smpl_valid,
  input  logic                        smpl_ready,
  output logic [P_PCM_RAM_DATA_W-1:0] smpl_lchnnl,
  output logic [P_PCM_RAM_DATA_W-1:0] smpl_rchnnl,
  output logic [P_PCM_RAM_ADDR_W-1:0] smpl_idx,
  output logic                        smpl_last,
  input  logic                        lb_rd_en,
  input  logic [P_PCM_RAM_ADDR_W:0]   lb_rd_addr,
  output logic                        lb_rd_valid,
  output logic [P_PCM_RAM_DATA_W-1:0] lb_rd_data,
  output logic                        busy,
  output logic                        frame_done_oh,
  output logic [7:0]                  ovrn_cnt,
  input  logic                        ovrn_clr,
  output logic                        tag_err
);

  localparam int DW     = P_PCM_RAM_DATA_W;
  localparam int AW     = P_PCM_RAM_ADDR_W;
  localparam int RD     = P_RAM_RD_DELAY;
  localparam int PTR_W  = $clog2(P_SKID_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(P_LB_MAX_WAIT + 1);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_t;

  state_t              state, state_nxt;
  logic [AW-1:0]       fetch_addr;
  logic [RD-1:0]       tag_vld, tag_lb;
  logic [CNT_W-1:0]    fetch_out, fifo_count;
  logic                fetch_elig, fetch_grant, lb_grant;
  logic                lb_pending, lb_sel, lb_busy, lb_accept, lb_ret;
  logic [AW-1:0]       lb_addr;
  logic [WAIT_W-1:0]   lb_wait;
  logic [DW-1:0]       fifo_l [P_SKID_DEPTH];
  logic [DW-1:0]       fifo_r [P_SKID_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [AW-1:0]       acc_idx;
  logic                head_vld, head_lb, push, pop;

  assign head_vld = tag_vld[RD-1];
  assign head_lb  = tag_lb[RD-1];
  assign push     = mem_rd_valid & head_vld & ~head_lb;
  assign lb_ret   = mem_rd_valid & head_vld & head_lb;

  assign smpl_valid    = (fifo_count != '0);
  assign pop           = smpl_valid & smpl_ready;
  assign smpl_lchnnl   = fifo_l[rd_ptr];
  assign smpl_rchnnl   = fifo_r[rd_ptr];
  assign smpl_idx      = acc_idx;
  assign smpl_last     = smpl_valid && (acc_idx == LAST_ADDR);
  assign frame_done_oh = pop & smpl_last;
  assign busy          = (state != ST_IDLE);

  // A debug read stays "busy" from acceptance until its data has come back,
  // so only one debug read is ever held or in flight.
  assign lb_busy   = lb_pending | (|(tag_vld & tag_lb));
  assign lb_accept = lb_rd_en & ~lb_busy;

  // Fetch reads still in the tag pipe; together with the FIFO fill this is
  // the credit that keeps the FIFO from ever overflowing.
  always_comb begin
    fetch_out = '0;
    for (int i = 0; i < RD; i++)
      if (tag_vld[i] && !tag_lb[i]) fetch_out = fetch_out + CNT_W'(1);
  end

  // Arbiter and next-state logic. The debug read takes the port when no
  // fetch read can go, or once it has waited long enough.
  always_comb begin
    state_nxt   = state;
    mem_rden    = 1'b0;
    mem_addr    = '0;
    fetch_elig  = (state == ST_FETCH) &&
                  ((fifo_count + fetch_out) < CNT_W'(P_SKID_DEPTH));
    lb_grant    = lb_pending && (!fetch_elig || (lb_wait >= WAIT_W'(P_LB_MAX_WAIT)));
    fetch_grant = fetch_elig && !lb_grant;
    if (lb_grant) begin
      mem_rden = 1'b1;
      mem_addr = lb_addr;
    end else if (fetch_grant) begin
      mem_rden = 1'b1;
      mem_addr = fetch_addr;
    end
    case (state)
      ST_IDLE:  if (pcm_rdy_oh && fetch_en) state_nxt = ST_FETCH;
      ST_FETCH: if (fetch_grant && (fetch_addr == LAST_ADDR)) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((fetch_out == '0) && (fifo_count == '0)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Fetch address is parked at 0 whenever idle, so every frame starts at 0.
  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir)                fetch_addr <= '0;
    else if (state == ST_IDLE) fetch_addr <= '0;
    else if (fetch_grant)      fetch_addr <= fetch_addr + AW'(1);
  end

  // Tag pipe mirrors the read latency; the head tag lines up with the
  // cycle in which that read's data returns.
  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      tag_vld <= '0;
      tag_lb  <= '0;
      tag_err <= 1'b0;
    end else begin
      tag_vld[0] <= mem_rden;
      tag_lb[0]  <= lb_grant;
      for (int i = 1; i < RD; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_lb[i]  <= tag_lb[i-1];
      end
      if (mem_rd_valid != head_vld) tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      acc_idx    <= '0;
      for (int i = 0; i < P_SKID_DEPTH; i++) begin
        fifo_l[i] <= '0;
        fifo_r[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_l[wr_ptr] <= mem_lrdata;
        fifo_r[wr_ptr] <= mem_rrdata;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        acc_idx <= acc_idx + AW'(1);
      end
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      lb_pending  <= 1'b0;
      lb_sel      <= 1'b0;
      lb_addr     <= '0;
      lb_wait     <= '0;
      lb_rd_valid <= 1'b0;
      lb_rd_data  <= '0;
    end else begin
      if (lb_accept) begin
        lb_pending <= 1'b1;
        lb_addr    <= lb_rd_addr[AW-1:0];
        lb_sel     <= lb_rd_addr[AW];
        lb_wait    <= '0;
      end else if (lb_grant) begin
        lb_pending <= 1'b0;
        lb_wait    <= '0;
      end else if (lb_pending && (lb_wait < WAIT_W'(P_LB_MAX_WAIT))) begin
        lb_wait <= lb_wait + WAIT_W'(1);
      end
      lb_rd_valid <= lb_ret;
      if (lb_ret) lb_rd_data <= lb_sel ? mem_rrdata : mem_lrdata;
    end
  end

  // Clear takes priority over a same-cycle overrun.
  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir)                                        ovrn_cnt <= '0;
    else if (ovrn_clr)                                 ovrn_cnt <= '0;
    else if (pcm_rdy_oh && busy && (ovrn_cnt != 8'hFF)) ovrn_cnt <= ovrn_cnt + 8'd1;
  end

endmodule
